// File: rtl/iomem_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : iomem_timer_if                                                  |
// | Brief    : picosoc iomem bus bundle, master drives requests, slave replies |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface iomem_timer_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid,
        output iomem_wstrb,
        output iomem_addr,
        output iomem_wdata,
        input  iomem_ready,
        input  iomem_rdata
    );

    modport slave (
        input  iomem_valid,
        input  iomem_wstrb,
        input  iomem_addr,
        input  iomem_wdata,
        output iomem_ready,
        output iomem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/iomem_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : iomem_timer                                                     |
// | Brief    : iomem-mapped 32-bit down-counting timer with prescaler,         |
// |            auto-reload and level irq. IOMEM_TIMER_CAPTURE_EN adds an       |
// |            input-capture register fed by capture_in.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module iomem_timer #(
    parameter logic [7:0] BASE_HI    = 8'h04,
    parameter int         PRESCALE_W = 16
) (
    input  logic          clk,
    input  logic          resetn,
    iomem_timer_if.slave  bus,
    input  logic          capture_in,
    output logic          irq
);

    localparam logic [5:0] c_OFF_CTRL     = 6'h00;
    localparam logic [5:0] c_OFF_PRESCALE = 6'h01;
    localparam logic [5:0] c_OFF_RELOAD   = 6'h02;
    localparam logic [5:0] c_OFF_COUNT    = 6'h03;
    localparam logic [5:0] c_OFF_STATUS   = 6'h04;
    localparam logic [5:0] c_OFF_CAPTURE  = 6'h05;

    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic                  r_en;
    logic                  r_auto;
    logic                  r_ie;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [31:0]           r_reload;
    logic [31:0]           r_count;
    logic                  r_exp;
    logic                  r_irq;

    logic                  w_sel;
    logic                  w_wr;
    logic [5:0]            w_off;
    logic                  w_wr_ctrl;
    logic                  w_wr_prescale;
    logic                  w_wr_reload;
    logic                  w_wr_count;
    logic                  w_wr_status;
    logic                  w_tick;
    logic                  w_expire;
    logic [31:0]           w_rdata;
    logic                  w_cap_flag;
    logic [31:0]           w_capture_val;
    logic                  w_unused_addr;

    logic                  w_en_n;
    logic                  w_auto_n;
    logic                  w_ie_n;
    logic [PRESCALE_W-1:0] w_prescale_n;
    logic [PRESCALE_W-1:0] w_pcnt_n;
    logic [31:0]           w_reload_n;
    logic [31:0]           w_count_n;
    logic                  w_exp_n;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // !r_ready keeps the request from being re-accepted during its own ready cycle
    assign w_sel = bus.iomem_valid && !r_ready && (bus.iomem_addr[31:24] == BASE_HI);
    assign w_wr  = w_sel && (bus.iomem_wstrb != 4'b0000);
    assign w_off = bus.iomem_addr[7:2];

    assign w_wr_ctrl     = w_wr && (w_off == c_OFF_CTRL);
    assign w_wr_prescale = w_wr && (w_off == c_OFF_PRESCALE);
    assign w_wr_reload   = w_wr && (w_off == c_OFF_RELOAD);
    assign w_wr_count    = w_wr && (w_off == c_OFF_COUNT);
    assign w_wr_status   = w_wr && (w_off == c_OFF_STATUS);

    assign w_unused_addr = ^{bus.iomem_addr[23:8], bus.iomem_addr[1:0]};

    assign w_tick   = r_en && (r_pcnt == r_prescale);
    assign w_expire = w_tick && (r_count == 32'd1);

    always_comb begin
        w_en_n       = r_en;
        w_auto_n     = r_auto;
        w_ie_n       = r_ie;
        w_prescale_n = r_prescale;
        w_reload_n   = r_reload;
        w_count_n    = r_count;
        w_exp_n      = r_exp;
        // Held at zero while stopped, so an EN 0->1 write always starts a fresh period
        w_pcnt_n     = '0;
        if (r_en && !w_tick) w_pcnt_n = r_pcnt + PRESCALE_W'(1);

        if (w_tick) begin
            if (r_count > 32'd1) begin
                w_count_n = r_count - 32'd1;
            end else begin
                w_count_n = r_auto ? r_reload : 32'd0;
                if (!r_auto) w_en_n = 1'b0;
            end
        end

        // Bus writes are applied after the tick so they take priority
        if (w_wr_ctrl && bus.iomem_wstrb[0]) begin
            w_en_n   = bus.iomem_wdata[0];
            w_auto_n = bus.iomem_wdata[1];
            w_ie_n   = bus.iomem_wdata[2];
        end
        if (w_wr_prescale)
            w_prescale_n = PRESCALE_W'(f_merge(32'(r_prescale), bus.iomem_wdata, bus.iomem_wstrb));
        if (w_wr_reload)
            w_reload_n = f_merge(r_reload, bus.iomem_wdata, bus.iomem_wstrb);
        if (w_wr_count) begin
            w_count_n = f_merge(r_count, bus.iomem_wdata, bus.iomem_wstrb);
            w_pcnt_n  = '0;
        end

        if (w_wr_status && bus.iomem_wstrb[0] && bus.iomem_wdata[0]) w_exp_n = 1'b0;
        if (w_expire) w_exp_n = 1'b1;
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            c_OFF_CTRL:     w_rdata = {29'd0, r_ie, r_auto, r_en};
            c_OFF_PRESCALE: w_rdata = 32'(r_prescale);
            c_OFF_RELOAD:   w_rdata = r_reload;
            c_OFF_COUNT:    w_rdata = r_count;
            c_OFF_STATUS:   w_rdata = {30'd0, w_cap_flag, r_exp};
            c_OFF_CAPTURE:  w_rdata = w_capture_val;
            default:        w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ready    <= 1'b0;
            r_rdata    <= 32'd0;
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_ie       <= 1'b0;
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_reload   <= 32'd0;
            r_count    <= 32'd0;
            r_exp      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_ready    <= w_sel;
            if (w_sel) r_rdata <= w_rdata;
            r_en       <= w_en_n;
            r_auto     <= w_auto_n;
            r_ie       <= w_ie_n;
            r_prescale <= w_prescale_n;
            r_pcnt     <= w_pcnt_n;
            r_reload   <= w_reload_n;
            r_count    <= w_count_n;
            r_exp      <= w_exp_n;
            r_irq      <= (r_exp | w_cap_flag) & r_ie;
        end
    end

`ifdef IOMEM_TIMER_CAPTURE_EN
    logic        r_cap_s1;
    logic        r_cap_s2;
    logic        r_cap_d;
    logic        r_cap;
    logic [31:0] r_capture;
    logic        w_cap_rise;

    assign w_cap_rise = r_cap_s2 & ~r_cap_d;

    // r_count here is the pre-edge value, so a coincident COUNT write is not seen
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cap_s1  <= 1'b0;
            r_cap_s2  <= 1'b0;
            r_cap_d   <= 1'b0;
            r_cap     <= 1'b0;
            r_capture <= 32'd0;
        end else begin
            r_cap_s1 <= capture_in;
            r_cap_s2 <= r_cap_s1;
            r_cap_d  <= r_cap_s2;
            if (w_cap_rise) begin
                r_cap     <= 1'b1;
                r_capture <= r_count;
            end else if (w_wr_status && bus.iomem_wstrb[0] && bus.iomem_wdata[1]) begin
                r_cap <= 1'b0;
            end
        end
    end

    assign w_cap_flag    = r_cap;
    assign w_capture_val = r_capture;
`else
    logic w_unused_capture;

    assign w_unused_capture = capture_in;
    assign w_cap_flag       = 1'b0;
    assign w_capture_val    = 32'd0;
`endif

    assign bus.iomem_ready = r_ready;
    assign bus.iomem_rdata = r_rdata;
    assign irq             = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_iomem_timer.sv
`default_nettype none
// Testbench for iomem_timer: directed and randomized bus sequences checked
// against timing formulas and a byte-merge shadow of the register map.
`timescale 1ns/1ps
module tb_iomem_timer;

    localparam logic [31:0] BASE = 32'h0400_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic capture_in = 1'b0;
    logic irq;

    iomem_timer_if bus();

    iomem_timer #(.BASE_HI(8'h04), .PRESCALE_W(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus.slave),
        .capture_in (capture_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) step();
    endtask

    // Issue one request; ready must appear on the next edge and last one cycle
    task automatic xfer(input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int sel_edge);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = addr;
        bus.iomem_wstrb = strb;
        bus.iomem_wdata = wdata;
        step();
        sel_edge = cyc;
        check("ready_pulse", 32'(bus.iomem_ready), 32'd1);
        rdata = bus.iomem_rdata;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        step();
        check("ready_width", 32'(bus.iomem_ready), 32'd0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, output int e);
        logic [31:0] dummy;
        xfer(BASE | 32'(off), 4'hF, d, dummy, e);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] d);
        int e;
        xfer(BASE | 32'(off), 4'h0, 32'h0, d, e);
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    task automatic wait_irq_rise(input int limit, output int edge_seen);
        edge_seen = -1;
        while (!irq && cyc < limit) step();
        if (irq) edge_seen = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] d;
    logic [31:0] sh[4];
    logic [31:0] v;
    logic [3:0]  s;
    int e, c0, got, p, n, sample_edge, cap_edge;

    initial begin
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wdata = 32'h0;
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;

        // Reset state
        check("irq_reset", 32'(irq), 32'd0);
        check("ready_reset", 32'(bus.iomem_ready), 32'd0);
        check("rdata_reset", bus.iomem_rdata, 32'd0);
        for (int i = 0; i < 6; i++) begin
            rd(8'(4 * i), d);
            check($sformatf("reset_reg_%0h", 4 * i), d, 32'd0);
        end
        check("irq_after_reads", 32'(irq), 32'd0);

        // Byte-lane write to RELOAD
        xfer(BASE | 32'h8, 4'b0010, 32'hAABB_CCDD, d, e);
        rd(8'h08, d);
        check("reload_bytelane", d, 32'h0000_CC00);

        // Foreign address never gets ready
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = 32'h0500_0000;
        bus.iomem_wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("unselected_ready", 32'(bus.iomem_ready), 32'd0);
        end
        bus.iomem_valid = 1'b0;
        step();

        // Unmapped offset: reads 0, write ignored
        wr(8'h40, 32'hFFFF_FFFF, e);
        rd(8'h40, d);
        check("unmapped_read", d, 32'd0);
        rd(8'h08, d);
        check("unmapped_no_side_effect", d, 32'h0000_CC00);

        // Random byte-lane writes against a shadow map (EN kept 0)
        sh[0] = 32'd0; sh[1] = 32'd0; sh[2] = 32'h0000_CC00; sh[3] = 32'd0;
        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(0, 3);
            s = 4'($urandom_range(1, 15));
            v = $urandom;
            if (n == 0) v[0] = 1'b0;
            xfer(BASE | 32'(4 * n), s, v, d, e);
            sh[n] = bmerge(sh[n], v, s);
            if (n == 0) sh[n] = sh[n] & 32'h7;
            if (n == 1) sh[n] = sh[n] & 32'hFFFF;
            rd(8'(4 * n), d);
            check($sformatf("rand_reg_%0h", 4 * n), d, sh[n]);
        end
        wr(8'h00, 32'h0, e);

        // One-shot, PRESCALE=0, COUNT=5: expiry lands on the 5th edge after EN
        wr(8'h04, 32'd0, e);
        wr(8'h0C, 32'd5, e);
        wr(8'h00, 32'h1, c0);
        wait_to(c0 + 4);
        rd(8'h10, d);
        check("oneshot_exp_before", d, 32'd0);
        rd(8'h10, d);
        check("oneshot_exp_after", d, 32'd1);
        rd(8'h0C, d);
        check("oneshot_count_zero", d, 32'd0);
        rd(8'h00, d);
        check("oneshot_ctrl_cleared", d, 32'd0);
        check("oneshot_irq_masked", 32'(irq), 32'd0);
        wr(8'h10, 32'h1, e);
        rd(8'h10, d);
        check("status_w1c", d, 32'd0);

        // Random one-shots with IE: irq rises one edge after COUNT*(PRESCALE+1)
        for (int i = 0; i < 4; i++) begin
            p = $urandom_range(0, 6);
            n = $urandom_range(1, 12);
            wr(8'h04, 32'(p), e);
            wr(8'h0C, 32'(n), e);
            wr(8'h00, 32'h5, c0);
            wait_irq_rise(c0 + n * (p + 1) + 6, got);
            check("rand_oneshot_irq_edge", 32'(got), 32'(c0 + n * (p + 1) + 1));
            rd(8'h00, d);
            check("rand_oneshot_ctrl", d, 32'h4);
            rd(8'h0C, d);
            check("rand_oneshot_count", d, 32'd0);
            wr(8'h10, 32'h1, e);
            check("rand_oneshot_irq_clear", 32'(irq), 32'd0);
        end
        wr(8'h00, 32'h0, e);

        // Periodic: PRESCALE=3, RELOAD=4 -> period 16
        wr(8'h04, 32'd3, e);
        wr(8'h08, 32'd4, e);
        wr(8'h0C, 32'd4, e);
        wr(8'h00, 32'h7, c0);
        wait_irq_rise(c0 + 24, got);
        check("periodic_irq_first", 32'(got), 32'(c0 + 17));
        wait_to(c0 + 19);
        wr(8'h10, 32'h1, e);
        check("periodic_irq_drop", 32'(irq), 32'd0);
        wait_irq_rise(c0 + 40, got);
        check("periodic_irq_second", 32'(got), 32'(c0 + 33));
        wait_to(c0 + 35);
        wr(8'h10, 32'h1, e);
        check("periodic_irq_drop2", 32'(irq), 32'd0);
        wait_to(c0 + 47);
        wr(8'h10, 32'h1, e);
        check("w1c_on_expiry_edge", 32'(e), 32'(c0 + 48));
        rd(8'h10, d);
        check("w1c_on_expiry_set_wins", d, 32'd1);
        check("w1c_on_expiry_irq", 32'(irq), 32'd1);
        wr(8'h00, 32'h0, e);
        wr(8'h10, 32'h1, e);

        // COUNT write on a tick edge wins; a later write restarts the prescaler
        wr(8'h04, 32'd3, e);
        wr(8'h0C, 32'd1000, e);
        wr(8'h00, 32'h1, c0);
        wait_to(c0 + 7);
        wr(8'h0C, 32'd100, e);
        rd(8'h0C, d);
        check("count_write_on_tick", d, 32'd100);
        wait_to(c0 + 13);
        wr(8'h0C, 32'd200, e);
        rd(8'h0C, d);
        check("count_write_hold_a", d, 32'd200);
        rd(8'h0C, d);
        check("count_write_pcnt_cleared", d, 32'd200);
        rd(8'h0C, d);
        check("count_after_restart_tick", d, 32'd199);
        wr(8'h00, 32'h0, e);

        // Reset during a request drops it and clears registers
        wr(8'h08, 32'h1234, e);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = BASE | 32'h8;
        bus.iomem_wstrb = 4'h0;
        resetn = 1'b0;
        step();
        check("reset_mid_ready", 32'(bus.iomem_ready), 32'd0);
        bus.iomem_valid = 1'b0;
        resetn = 1'b1;
        step();
        rd(8'h08, d);
        check("reset_mid_reload", d, 32'd0);
        check("reset_mid_irq", 32'(irq), 32'd0);

        // Input capture
        wr(8'h04, 32'd0, e);
        wr(8'h0C, 32'd1000, e);
        wr(8'h00, 32'h5, c0);
        wait_to(c0 + 10);
        capture_in = 1'b1;
        step();
        sample_edge = cyc;
        capture_in = 1'b0;
`ifdef IOMEM_TIMER_CAPTURE_EN
        cap_edge = sample_edge + 2;
        wait_to(cap_edge);
        check("capture_irq_before", 32'(irq), 32'd0);
        step();
        check("capture_irq", 32'(irq), 32'd1);
        rd(8'h14, d);
        check("capture_value", d, 32'(1000 - (cap_edge - 1 - c0)));
        rd(8'h10, d);
        check("capture_status", d, 32'h2);
        wr(8'h10, 32'h2, e);
        check("capture_w1c_irq", 32'(irq), 32'd0);
`else
        cap_edge = sample_edge + 6;
        wait_to(cap_edge);
        check("nocapture_irq", 32'(irq), 32'd0);
        rd(8'h14, d);
        check("nocapture_reg", d, 32'd0);
        rd(8'h10, d);
        check("nocapture_status", d, 32'd0);
`endif
        wr(8'h00, 32'h0, e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
